// File: rtl/host_mem_rdwr_arb_2to1.sv
// host_mem_rdwr_arb_2to1: round-robin merge of two Avalon rdwr host-memory sources onto one sink with in-order response routing
module host_mem_rdwr_arb_2to1 #(
  parameter int ADDR_WIDTH     = 42,
  parameter int DATA_WIDTH     = 512,
  parameter int BURST_WIDTH    = 7,
  parameter int USER_WIDTH     = 8,
  parameter int RD_TRACK_DEPTH = 64,
  parameter int WR_TRACK_DEPTH = 64
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic [ADDR_WIDTH-1:0]   s0_rd_address,
  input  logic [BURST_WIDTH-1:0]  s0_rd_burstcount,
  input  logic [USER_WIDTH-1:0]   s0_rd_user,
  input  logic                    s0_rd_read,
  output logic                    s0_rd_waitrequest,
  output logic [DATA_WIDTH-1:0]   s0_rd_readdata,
  output logic                    s0_rd_readdatavalid,
  input  logic [ADDR_WIDTH-1:0]   s0_wr_address,
  input  logic [BURST_WIDTH-1:0]  s0_wr_burstcount,
  input  logic [USER_WIDTH-1:0]   s0_wr_user,
  input  logic                    s0_wr_write,
  input  logic [DATA_WIDTH-1:0]   s0_wr_writedata,
  input  logic [DATA_WIDTH/8-1:0] s0_wr_byteenable,
  output logic                    s0_wr_waitrequest,
  output logic                    s0_wr_writeresponsevalid,
  input  logic [ADDR_WIDTH-1:0]   s1_rd_address,
  input  logic [BURST_WIDTH-1:0]  s1_rd_burstcount,
  input  logic [USER_WIDTH-1:0]   s1_rd_user,
  input  logic                    s1_rd_read,
  output logic                    s1_rd_waitrequest,
  output logic [DATA_WIDTH-1:0]   s1_rd_readdata,
  output logic                    s1_rd_readdatavalid,
  input  logic [ADDR_WIDTH-1:0]   s1_wr_address,
  input  logic [BURST_WIDTH-1:0]  s1_wr_burstcount,
  input  logic [USER_WIDTH-1:0]   s1_wr_user,
  input  logic                    s1_wr_write,
  input  logic [DATA_WIDTH-1:0]   s1_wr_writedata,
  input  logic [DATA_WIDTH/8-1:0] s1_wr_byteenable,
  output logic                    s1_wr_waitrequest,
  output logic                    s1_wr_writeresponsevalid,
  output logic [ADDR_WIDTH-1:0]   m_rd_address,
  output logic [BURST_WIDTH-1:0]  m_rd_burstcount,
  output logic [USER_WIDTH-1:0]   m_rd_user,
  output logic                    m_rd_read,
  input  logic                    m_rd_waitrequest,
  input  logic [DATA_WIDTH-1:0]   m_rd_readdata,
  input  logic                    m_rd_readdatavalid,
  output logic [ADDR_WIDTH-1:0]   m_wr_address,
  output logic [BURST_WIDTH-1:0]  m_wr_burstcount,
  output logic [USER_WIDTH-1:0]   m_wr_user,
  output logic                    m_wr_write,
  output logic [DATA_WIDTH-1:0]   m_wr_writedata,
  output logic [DATA_WIDTH/8-1:0] m_wr_byteenable,
  input  logic                    m_wr_waitrequest,
  input  logic                    m_wr_writeresponsevalid,
  output logic                    err_unexpected_rsp
);
  localparam int RAW = $clog2(RD_TRACK_DEPTH);
  localparam int WAW = $clog2(WR_TRACK_DEPTH);
  typedef enum logic {IDLE, BURST} wr_state_t;
  logic                   rd_rr, rd_sel, rd_acc, rd_full, rd_empty, rd_push, rd_pop, rd_beat_ok, rd_last;
  logic [1:0]             rd_req, rd_grant, rd_dv_q;
  logic [BURST_WIDTH:0]   rd_mem [RD_TRACK_DEPTH];
  logic [RAW-1:0]         rd_wp, rd_rp;
  logic [RAW:0]           rd_cnt;
  logic                   rd_h_src;
  logic [BURST_WIDTH-1:0] rd_h_bc, rd_beats, rd_cur;
  logic [DATA_WIDTH-1:0]  rd_data_q;
  wr_state_t              wr_st, wr_st_nx;
  logic                   wr_rr, wr_rr_nx, wr_src, wr_src_nx, wr_first, wr_sel, wr_acc, wr_push, wr_pop;
  logic                   wr_full, wr_empty;
  logic [1:0]             wr_req, wr_arb, wr_grant, wr_rsp_q;
  logic [BURST_WIDTH-1:0] wr_rem, wr_rem_nx;
  logic [WR_TRACK_DEPTH-1:0] wr_mem;
  logic [WAW-1:0]         wr_wp, wr_rp;
  logic [WAW:0]           wr_cnt;
  logic                   err_q;
  assign rd_req   = {s1_rd_read, s0_rd_read};
  assign rd_grant = &rd_req ? (rd_rr ? 2'b10 : 2'b01) : rd_req;
  assign rd_sel   = rd_grant[1];
  assign rd_full  = rd_cnt[RAW];
  assign rd_empty = rd_cnt == '0;
  assign m_rd_read       = reset_n && |rd_req && !rd_full;
  assign m_rd_address    = rd_sel ? s1_rd_address : s0_rd_address;
  assign m_rd_burstcount = rd_sel ? s1_rd_burstcount : s0_rd_burstcount;
  assign m_rd_user       = rd_sel ? s1_rd_user : s0_rd_user;
  assign s0_rd_waitrequest = !reset_n || !rd_grant[0] || m_rd_waitrequest || rd_full;
  assign s1_rd_waitrequest = !reset_n || !rd_grant[1] || m_rd_waitrequest || rd_full;
  assign rd_acc  = m_rd_read && !m_rd_waitrequest;
  assign rd_push = rd_acc;
  assign {rd_h_src, rd_h_bc} = rd_mem[rd_rp];
  // Beat counter of zero means the head burst has not started yet
  assign rd_cur     = rd_beats == '0 ? rd_h_bc : rd_beats;
  assign rd_last    = rd_cur[BURST_WIDTH-1:1] == '0;
  assign rd_beat_ok = m_rd_readdatavalid && !rd_empty;
  assign rd_pop     = rd_beat_ok && rd_last;
  assign s0_rd_readdata      = rd_data_q;
  assign s1_rd_readdata      = rd_data_q;
  assign s0_rd_readdatavalid = rd_dv_q[0];
  assign s1_rd_readdatavalid = rd_dv_q[1];
  always_ff @(posedge clk) begin
    if (rd_push) rd_mem[rd_wp] <= {rd_sel, m_rd_burstcount};
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_rr     <= 1'b0;
      rd_wp     <= '0;
      rd_rp     <= '0;
      rd_cnt    <= '0;
      rd_beats  <= '0;
      rd_dv_q   <= 2'b00;
      rd_data_q <= '0;
    end else begin
      if (rd_acc) rd_rr <= !rd_sel;
      if (rd_push) rd_wp <= rd_wp + RAW'(1);
      if (rd_pop) rd_rp <= rd_rp + RAW'(1);
      rd_cnt <= rd_cnt + (RAW+1)'(rd_push) - (RAW+1)'(rd_pop);
      if (rd_beat_ok) rd_beats <= rd_last ? '0 : rd_cur - BURST_WIDTH'(1);
      rd_dv_q <= rd_beat_ok ? (rd_h_src ? 2'b10 : 2'b01) : 2'b00;
      if (m_rd_readdatavalid) rd_data_q <= m_rd_readdata;
    end
  end
  assign wr_req   = {s1_wr_write, s0_wr_write};
  assign wr_arb   = &wr_req ? (wr_rr ? 2'b10 : 2'b01) : wr_req;
  assign wr_first = wr_st == IDLE;
  assign wr_grant = wr_first ? wr_arb : (wr_src ? 2'b10 : 2'b01);
  assign wr_sel   = wr_grant[1];
  assign wr_full  = wr_cnt[WAW];
  assign wr_empty = wr_cnt == '0;
  assign m_wr_write      = reset_n && |(wr_grant & wr_req) && !(wr_first && wr_full);
  assign m_wr_address    = wr_sel ? s1_wr_address : s0_wr_address;
  assign m_wr_burstcount = wr_sel ? s1_wr_burstcount : s0_wr_burstcount;
  assign m_wr_user       = wr_sel ? s1_wr_user : s0_wr_user;
  assign m_wr_writedata  = wr_sel ? s1_wr_writedata : s0_wr_writedata;
  assign m_wr_byteenable = wr_sel ? s1_wr_byteenable : s0_wr_byteenable;
  assign s0_wr_waitrequest = !reset_n || !wr_grant[0] || m_wr_waitrequest || (wr_first && wr_full);
  assign s1_wr_waitrequest = !reset_n || !wr_grant[1] || m_wr_waitrequest || (wr_first && wr_full);
  assign wr_acc  = m_wr_write && !m_wr_waitrequest;
  assign wr_push = wr_acc && wr_first;
  assign wr_pop  = m_wr_writeresponsevalid && !wr_empty;
  assign s0_wr_writeresponsevalid = wr_rsp_q[0];
  assign s1_wr_writeresponsevalid = wr_rsp_q[1];
  always_comb begin
    wr_st_nx  = wr_st;
    wr_rr_nx  = wr_rr;
    wr_src_nx = wr_src;
    wr_rem_nx = wr_rem;
    if (wr_acc && wr_first) begin
      wr_src_nx = wr_sel;
      wr_rem_nx = m_wr_burstcount - BURST_WIDTH'(1);
      wr_st_nx  = m_wr_burstcount[BURST_WIDTH-1:1] == '0 ? IDLE : BURST;
      wr_rr_nx  = m_wr_burstcount[BURST_WIDTH-1:1] == '0 ? !wr_sel : wr_rr;
    end else if (wr_acc) begin
      wr_rem_nx = wr_rem - BURST_WIDTH'(1);
      wr_st_nx  = wr_rem[BURST_WIDTH-1:1] == '0 ? IDLE : BURST;
      wr_rr_nx  = wr_rem[BURST_WIDTH-1:1] == '0 ? !wr_src : wr_rr;
    end
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_st    <= IDLE;
      wr_rr    <= 1'b0;
      wr_src   <= 1'b0;
      wr_rem   <= '0;
      wr_mem   <= '0;
      wr_wp    <= '0;
      wr_rp    <= '0;
      wr_cnt   <= '0;
      wr_rsp_q <= 2'b00;
      err_q    <= 1'b0;
    end else begin
      wr_st  <= wr_st_nx;
      wr_rr  <= wr_rr_nx;
      wr_src <= wr_src_nx;
      wr_rem <= wr_rem_nx;
      if (wr_push) wr_mem[wr_wp] <= wr_sel;
      if (wr_push) wr_wp <= wr_wp + WAW'(1);
      if (wr_pop) wr_rp <= wr_rp + WAW'(1);
      wr_cnt   <= wr_cnt + (WAW+1)'(wr_push) - (WAW+1)'(wr_pop);
      wr_rsp_q <= wr_pop ? (wr_mem[wr_rp] ? 2'b10 : 2'b01) : 2'b00;
      err_q    <= err_q || (m_rd_readdatavalid && rd_empty) || (m_wr_writeresponsevalid && wr_empty);
    end
  end
  assign err_unexpected_rsp = err_q;
endmodule

// File: tb/tb_host_mem_rdwr_arb_2to1.sv
// tb_host_mem_rdwr_arb_2to1: directed self-checking bench for the 2:1 host-memory rdwr arbiter
module tb_host_mem_rdwr_arb_2to1;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic          reset_n;
  logic [41:0]   s0_rd_address, s1_rd_address, m_rd_address;
  logic [6:0]    s0_rd_burstcount, s1_rd_burstcount, m_rd_burstcount;
  logic [7:0]    s0_rd_user, s1_rd_user, m_rd_user;
  logic          s0_rd_read, s1_rd_read, m_rd_read;
  logic          s0_rd_waitrequest, s1_rd_waitrequest, m_rd_waitrequest;
  logic [511:0]  s0_rd_readdata, s1_rd_readdata, m_rd_readdata;
  logic          s0_rd_readdatavalid, s1_rd_readdatavalid, m_rd_readdatavalid;
  logic [41:0]   s0_wr_address, s1_wr_address, m_wr_address;
  logic [6:0]    s0_wr_burstcount, s1_wr_burstcount, m_wr_burstcount;
  logic [7:0]    s0_wr_user, s1_wr_user, m_wr_user;
  logic          s0_wr_write, s1_wr_write, m_wr_write;
  logic [511:0]  s0_wr_writedata, s1_wr_writedata, m_wr_writedata;
  logic [63:0]   s0_wr_byteenable, s1_wr_byteenable, m_wr_byteenable;
  logic          s0_wr_waitrequest, s1_wr_waitrequest, m_wr_waitrequest;
  logic          s0_wr_writeresponsevalid, s1_wr_writeresponsevalid, m_wr_writeresponsevalid;
  logic          err_unexpected_rsp;
  int checks = 0;
  int failures = 0;
  int dst;

  host_mem_rdwr_arb_2to1 dut (
    .clk(clk), .reset_n(reset_n),
    .s0_rd_address(s0_rd_address), .s0_rd_burstcount(s0_rd_burstcount), .s0_rd_user(s0_rd_user),
    .s0_rd_read(s0_rd_read), .s0_rd_waitrequest(s0_rd_waitrequest), .s0_rd_readdata(s0_rd_readdata),
    .s0_rd_readdatavalid(s0_rd_readdatavalid),
    .s0_wr_address(s0_wr_address), .s0_wr_burstcount(s0_wr_burstcount), .s0_wr_user(s0_wr_user),
    .s0_wr_write(s0_wr_write), .s0_wr_writedata(s0_wr_writedata), .s0_wr_byteenable(s0_wr_byteenable),
    .s0_wr_waitrequest(s0_wr_waitrequest), .s0_wr_writeresponsevalid(s0_wr_writeresponsevalid),
    .s1_rd_address(s1_rd_address), .s1_rd_burstcount(s1_rd_burstcount), .s1_rd_user(s1_rd_user),
    .s1_rd_read(s1_rd_read), .s1_rd_waitrequest(s1_rd_waitrequest), .s1_rd_readdata(s1_rd_readdata),
    .s1_rd_readdatavalid(s1_rd_readdatavalid),
    .s1_wr_address(s1_wr_address), .s1_wr_burstcount(s1_wr_burstcount), .s1_wr_user(s1_wr_user),
    .s1_wr_write(s1_wr_write), .s1_wr_writedata(s1_wr_writedata), .s1_wr_byteenable(s1_wr_byteenable),
    .s1_wr_waitrequest(s1_wr_waitrequest), .s1_wr_writeresponsevalid(s1_wr_writeresponsevalid),
    .m_rd_address(m_rd_address), .m_rd_burstcount(m_rd_burstcount), .m_rd_user(m_rd_user),
    .m_rd_read(m_rd_read), .m_rd_waitrequest(m_rd_waitrequest), .m_rd_readdata(m_rd_readdata),
    .m_rd_readdatavalid(m_rd_readdatavalid),
    .m_wr_address(m_wr_address), .m_wr_burstcount(m_wr_burstcount), .m_wr_user(m_wr_user),
    .m_wr_write(m_wr_write), .m_wr_writedata(m_wr_writedata), .m_wr_byteenable(m_wr_byteenable),
    .m_wr_waitrequest(m_wr_waitrequest), .m_wr_writeresponsevalid(m_wr_writeresponsevalid),
    .err_unexpected_rsp(err_unexpected_rsp)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    reset_n = 1'b0;
    s0_rd_address = 42'h100; s0_rd_burstcount = 7'd4; s0_rd_user = 8'h0A; s0_rd_read = 1'b0;
    s1_rd_address = 42'h200; s1_rd_burstcount = 7'd4; s1_rd_user = 8'h0B; s1_rd_read = 1'b0;
    s0_wr_address = 42'h300; s0_wr_burstcount = 7'd8; s0_wr_user = 8'h0C; s0_wr_write = 1'b0;
    s1_wr_address = 42'h400; s1_wr_burstcount = 7'd1; s1_wr_user = 8'h0D; s1_wr_write = 1'b0;
    s0_wr_writedata = '0; s0_wr_byteenable = '1; s1_wr_writedata = '1; s1_wr_byteenable = '1;
    m_rd_waitrequest = 1'b0; m_rd_readdata = '0; m_rd_readdatavalid = 1'b0;
    m_wr_waitrequest = 1'b0; m_wr_writeresponsevalid = 1'b0;
    tick; tick;
    s0_rd_read = 1'b1; s0_wr_write = 1'b1;
    #1;
    chk("rst_m_rd_read", m_rd_read, 1'b0);
    chk("rst_m_wr_write", m_wr_write, 1'b0);
    chk("rst_s0_rd_wait", s0_rd_waitrequest, 1'b1);
    chk("rst_s0_wr_wait", s0_wr_waitrequest, 1'b1);
    chk("rst_s1_rd_wait", s1_rd_waitrequest, 1'b1);
    chk("rst_s1_wr_wait", s1_wr_waitrequest, 1'b1);
    chk("rst_s0_rdv", s0_rd_readdatavalid, 1'b0);
    chk("rst_s0_rdata", s0_rd_readdata, 512'h0);
    chk("rst_err", err_unexpected_rsp, 1'b0);
    s0_rd_read = 1'b0; s0_wr_write = 1'b0;
    tick;
    reset_n = 1'b1;
    tick;
    s0_rd_read = 1'b1; s1_rd_read = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("t1_grant_addr", m_rd_address, (i % 2) ? 42'h200 : 42'h100);
      chk("t1_m_rd_read", m_rd_read, 1'b1);
      chk("t1_s0_wait", s0_rd_waitrequest, (i % 2) == 1);
      chk("t1_s1_wait", s1_rd_waitrequest, (i % 2) == 0);
      tick;
    end
    s0_rd_read = 1'b0; s1_rd_read = 1'b0;
    for (int i = 0; i < 16; i++) begin
      m_rd_readdatavalid = 1'b1;
      m_rd_readdata = 512'(i + 1);
      tick;
      dst = (i / 4) % 2;
      chk("t1_s0_rdv", s0_rd_readdatavalid, dst == 0);
      chk("t1_s1_rdv", s1_rd_readdatavalid, dst == 1);
      chk("t1_s0_rdata", s0_rd_readdata, 512'(i + 1));
      chk("t1_s1_rdata", s1_rd_readdata, 512'(i + 1));
    end
    m_rd_readdatavalid = 1'b0;
    tick;
    chk("t1_s0_rdv_idle", s0_rd_readdatavalid, 1'b0);
    chk("t1_s1_rdv_idle", s1_rd_readdatavalid, 1'b0);
    chk("t1_err", err_unexpected_rsp, 1'b0);
    s0_wr_write = 1'b1;
    for (int b = 0; b < 8; b++) begin
      if (b == 2) s1_wr_write = 1'b1;
      s0_wr_writedata = 512'(b);
      #1;
      chk("t2_s0_wait", s0_wr_waitrequest, 1'b0);
      chk("t2_s1_wait", s1_wr_waitrequest, 1'b1);
      chk("t2_m_wdata", m_wr_writedata, 512'(b));
      tick;
    end
    s0_wr_write = 1'b0;
    #1;
    chk("t2_s1_granted", s1_wr_waitrequest, 1'b0);
    chk("t2_s1_addr", m_wr_address, 42'h400);
    chk("t2_m_wr_write", m_wr_write, 1'b1);
    tick;
    s1_wr_write = 1'b0;
    m_wr_writeresponsevalid = 1'b1;
    tick;
    chk("t2_rsp1_s0", s0_wr_writeresponsevalid, 1'b1);
    chk("t2_rsp1_s1", s1_wr_writeresponsevalid, 1'b0);
    tick;
    m_wr_writeresponsevalid = 1'b0;
    chk("t2_rsp2_s0", s0_wr_writeresponsevalid, 1'b0);
    chk("t2_rsp2_s1", s1_wr_writeresponsevalid, 1'b1);
    tick;
    chk("t2_rsp_idle_s1", s1_wr_writeresponsevalid, 1'b0);
    chk("t2_err", err_unexpected_rsp, 1'b0);
    s0_rd_burstcount = 7'd1; s1_rd_burstcount = 7'd1;
    s0_rd_read = 1'b1;
    #1;
    chk("t6_pre_s0_wait", s0_rd_waitrequest, 1'b0);
    tick;
    s0_rd_read = 1'b0;
    m_rd_readdatavalid = 1'b1; m_rd_readdata = 512'h55;
    tick;
    m_rd_readdatavalid = 1'b0;
    chk("t6_pre_s0_rdv", s0_rd_readdatavalid, 1'b1);
    chk("t6_pre_rdata", s0_rd_readdata, 512'h55);
    m_rd_waitrequest = 1'b1;
    s0_rd_read = 1'b1; s1_rd_read = 1'b1;
    for (int i = 0; i < 10; i++) begin
      #1;
      chk("t6_stall_s0", s0_rd_waitrequest, 1'b1);
      chk("t6_stall_s1", s1_rd_waitrequest, 1'b1);
      chk("t6_stall_ptr", m_rd_address, 42'h200);
      tick;
    end
    m_rd_waitrequest = 1'b0;
    #1;
    chk("t6_rel_s1", s1_rd_waitrequest, 1'b0);
    chk("t6_rel_s0", s0_rd_waitrequest, 1'b1);
    tick;
    s0_rd_read = 1'b0; s1_rd_read = 1'b0;
    m_rd_readdatavalid = 1'b1;
    tick;
    m_rd_readdatavalid = 1'b0;
    chk("t6_ret_s1", s1_rd_readdatavalid, 1'b1);
    chk("t6_ret_s0", s0_rd_readdatavalid, 1'b0);
    tick;
    m_rd_readdatavalid = 1'b1;
    tick;
    m_rd_readdatavalid = 1'b0;
    chk("t4_s0_rdv", s0_rd_readdatavalid, 1'b0);
    chk("t4_s1_rdv", s1_rd_readdatavalid, 1'b0);
    chk("t4_err_set", err_unexpected_rsp, 1'b1);
    tick; tick;
    chk("t4_err_held", err_unexpected_rsp, 1'b1);
    s0_wr_write = 1'b1;
    tick; tick;
    reset_n = 1'b0;
    #1;
    chk("t5_s0_wr_wait", s0_wr_waitrequest, 1'b1);
    chk("t5_m_wr_write", m_wr_write, 1'b0);
    chk("t5_err_clr", err_unexpected_rsp, 1'b0);
    chk("t5_s0_rd_wait", s0_rd_waitrequest, 1'b1);
    tick;
    reset_n = 1'b1;
    s0_wr_write = 1'b0; s1_wr_write = 1'b1;
    #1;
    chk("t5_s1_granted", s1_wr_waitrequest, 1'b0);
    chk("t5_s1_addr", m_wr_address, 42'h400);
    tick;
    s1_wr_write = 1'b0;
    m_wr_writeresponsevalid = 1'b1;
    tick;
    m_wr_writeresponsevalid = 1'b0;
    chk("t5_rsp_s1", s1_wr_writeresponsevalid, 1'b1);
    chk("t5_rsp_s0", s0_wr_writeresponsevalid, 1'b0);
    chk("t5_err", err_unexpected_rsp, 1'b0);
    s1_rd_read = 1'b1;
    for (int i = 0; i < 64; i++) begin
      #1;
      chk("t3_fill_wait", s1_rd_waitrequest, 1'b0);
      tick;
    end
    #1;
    chk("t3_full_wait", s1_rd_waitrequest, 1'b1);
    chk("t3_full_m_read", m_rd_read, 1'b0);
    m_rd_readdatavalid = 1'b1;
    #1;
    chk("t3_pop_cycle_wait", s1_rd_waitrequest, 1'b1);
    tick;
    m_rd_readdatavalid = 1'b0;
    #1;
    chk("t3_after_pop_wait", s1_rd_waitrequest, 1'b0);
    chk("t3_ret_s1", s1_rd_readdatavalid, 1'b1);
    tick;
    #1;
    chk("t3_refull_wait", s1_rd_waitrequest, 1'b1);
    s1_rd_read = 1'b0;
    tick;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/host_mem_rdwr_arb_2to1.md
Name: host_mem_rdwr_arb_2to1

Overview:
- Merges two shim-facing physical-address Avalon rdwr host-memory sources onto one host-memory sink: source 0 = DMA, source 1 = USM kernel.
- Sits directly downstream of the VTP translation stages and feeds one host memory channel.
- Arbitrates read commands and write bursts round-robin.
- Routes in-order read data and write responses back to the issuing source through order-tracking FIFOs.

Parameters:
- ADDR_WIDTH, 42, line address width.
- DATA_WIDTH, 512, data bus width in bits.
- BURST_WIDTH, 7, burstcount width; max burst = 2^(BURST_WIDTH-1).
- USER_WIDTH, 8, user field width; passed through unchanged.
- RD_TRACK_DEPTH, 64, max outstanding read commands; power of 2.
- WR_TRACK_DEPTH, 64, max outstanding write bursts awaiting response; power of 2.

Ports (sN_ = s0_ and s1_, one set each):
- clk  in  1  clock
- reset_n  in  1  asynchronous active-low reset
- sN_rd_address / sN_rd_burstcount / sN_rd_user  in  ADDR_WIDTH / BURST_WIDTH / USER_WIDTH  read command
- sN_rd_read  in  1  read request
- sN_rd_waitrequest  out  1  read command stall
- sN_rd_readdata  out  DATA_WIDTH  read data
- sN_rd_readdatavalid  out  1  read beat valid
- sN_wr_address / sN_wr_burstcount / sN_wr_user  in  ADDR_WIDTH / BURST_WIDTH / USER_WIDTH  write command; sampled on first beat
- sN_wr_write  in  1  write beat valid
- sN_wr_writedata / sN_wr_byteenable  in  DATA_WIDTH / DATA_WIDTH/8  write beat
- sN_wr_waitrequest  out  1  write stall
- sN_wr_writeresponsevalid  out  1  one pulse per completed burst
- m_rd_* / m_wr_*  out/in  same widths  sink-side mirror of the source ports above (commands out; waitrequest, readdata, readdatavalid, writeresponsevalid in)
- err_unexpected_rsp  out  1  sticky; set on a response with empty tracker

Behaviour:
- Handshake: a command/beat is accepted when valid && !waitrequest. Sink command outputs are combinational from the granted source.
  - sN_rd_waitrequest = !rd_grant[N] || m_rd_waitrequest || rd_trk_full.
  - sN_wr_waitrequest = !wr_grant[N] || m_wr_waitrequest || (first beat && wr_trk_full).
- Read arbitration, per command:
  - rd_rr pointer holds the preferred source. Both request -> grant the pointer; one requests -> grant it.
  - On acceptance, pointer moves to the other source.
  - Tracker push {src, burstcount}; push blocked when full, even if a pop occurs the same cycle.
- Read return, 1-cycle registered latency:
  - Each m_rd_readdatavalid beat goes to the tracker-head source; the other source sees readdatavalid=0. readdata is registered and copied to both sources.
  - Beat counter loads the head burstcount and decrements; pop on the last beat.
  - Beat with empty tracker -> beat dropped, err_unexpected_rsp=1 until reset.
- Write arbitration, per burst. States:
  - IDLE: arbitrate like reads using wr_rr. On first-beat acceptance: latch the source, push the source into the write tracker, load remaining = burstcount-1. burstcount==1 -> stay IDLE; else -> BURST.
  - BURST: grant locked to the latched source. The other source is stalled regardless of its request. Decrement per accepted beat; remaining hits 0 -> IDLE and advance wr_rr.
  - Burstcount 1 in IDLE also advances wr_rr.
- Write response: each m_wr_writeresponsevalid pulses sN_wr_writeresponsevalid for the write-tracker-head source one cycle later, then pops the head. Empty write tracker -> set err_unexpected_rsp.
- Simultaneous read and write grants are independent; both channels may transfer the same cycle.
- Reset (async assert, sync deassert usage):
  - Pointers prefer s0; write FSM=IDLE; trackers empty; counters 0; err_unexpected_rsp=0.
  - All sN_*waitrequest=1; all valid/pulse outputs=0; readdata=0.
  - m_rd_read and m_wr_write=0 while reset_n=0.
- Reset mid-burst or with reads outstanding discards all tracking state. Sink-side in-flight responses arriving after reset set err_unexpected_rsp; this is the defined behaviour.

Test Plan:
- Both sources assert rd_read, burstcount 4, continuously for 4 commands -> sink sees sources 0,1,0,1. Returned beats: 4 to s0, 4 to s1, alternating in order; err stays 0.
- s0 write burst of 8 while s1 requests from cycle 2 -> s1_wr_waitrequest=1 for all 8 s0 beats. s1 is granted on the cycle after s0's last beat. Two writeresponsevalid pulses route s0 then s1.
- Issue 64 reads from s1 with no responses -> 65th stalls (s1_rd_waitrequest=1). One full burst returned -> next command accepted the cycle after the pop.
- Inject m_rd_readdatavalid with nothing outstanding -> no sN_rd_readdatavalid; err_unexpected_rsp=1 and held until reset_n=0.
- Assert reset_n=0 during an s0 burst at beat 3 of 8 -> outputs go to reset values immediately. After release, s1 burstcount-1 write is granted first; FSM in IDLE.
- m_rd_waitrequest=1 for 10 cycles with both requesting -> no acceptance, pointer unchanged. First grant after release goes to the pre-stall preferred source.
